// File: rtl/alu_calc_ctrl_pkg.sv
// Shared definitions for the calculator controller: ALU operation codes,
// switch encodings for op_sel and the controller state type.
package calc_pkg;

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_LT  = 4'b0111;
    localparam logic [3:0] ALUOP_SLL = 4'b1001;
    localparam logic [3:0] ALUOP_SRA = 4'b1010;
    localparam logic [3:0] ALUOP_XOR = 4'b1101;

    localparam logic [2:0] OPSEL_ADD = 3'b000;
    localparam logic [2:0] OPSEL_SUB = 3'b001;
    localparam logic [2:0] OPSEL_AND = 3'b010;
    localparam logic [2:0] OPSEL_OR  = 3'b011;
    localparam logic [2:0] OPSEL_XOR = 3'b100;
    localparam logic [2:0] OPSEL_LT  = 3'b101;
    localparam logic [2:0] OPSEL_SLL = 3'b110;
    localparam logic [2:0] OPSEL_SRA = 3'b111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } calc_state_e;

    // Only the eight defined ALU codes can come out of this translation.
    function automatic logic [3:0] map_alu_op(input logic [2:0] sel);
        logic [3:0] op_s;
        case (sel)
            OPSEL_ADD: op_s = ALUOP_ADD;
            OPSEL_SUB: op_s = ALUOP_SUB;
            OPSEL_AND: op_s = ALUOP_AND;
            OPSEL_OR:  op_s = ALUOP_OR;
            OPSEL_XOR: op_s = ALUOP_XOR;
            OPSEL_LT:  op_s = ALUOP_LT;
            OPSEL_SLL: op_s = ALUOP_SLL;
            OPSEL_SRA: op_s = ALUOP_SRA;
            default:   op_s = ALUOP_ADD;
        endcase
        return op_s;
    endfunction

endpackage

// File: rtl/alu_calc_ctrl_if.sv
// Bus between the calculator controller (master) and the combinational ALU
// (slave): operands and opcode out, result and zero flag back.
interface alu_calc_ctrl_if;
    import calc_pkg::*;

    logic [3:0]  alu_op;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_result;
    logic        alu_zero;

    modport master (
        output alu_op,
        output alu_op1,
        output alu_op2,
        input  alu_result,
        input  alu_zero
    );

    modport slave (
        input  alu_op,
        input  alu_op1,
        input  alu_op2,
        output alu_result,
        output alu_zero
    );

endinterface

// File: rtl/alu_calc_ctrl_btn_oneshot.sv
// Button conditioner: two-flop synchronizer followed by a registered
// rising-edge detector, so a held button produces a single one-cycle pulse.
module btn_oneshot (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic meta_r;
    logic sync_r;
    logic sync_d_r;
    logic pulse_r;

    // Synchronizer chain and edge-detect pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r   <= 1'b0;
            sync_r   <= 1'b0;
            sync_d_r <= 1'b0;
            pulse_r  <= 1'b0;
        end else begin
            meta_r   <= in;
            sync_r   <= meta_r;
            sync_d_r <= sync_r;
            pulse_r  <= sync_r & ~sync_d_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/alu_calc_ctrl.sv
// Calculator controller around a combinational ALU: conditioned buttons drive
// accumulator updates, clears and undos from a circular LIFO history.
module alu_calc_ctrl
    import calc_pkg::*;
#(
    parameter int OPERAND_W  = 16,
    parameter int HIST_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              go,
    input  logic                              undo,
    input  logic                              clear,
    input  logic [2:0]                        op_sel,
    input  logic [OPERAND_W-1:0]              operand,
    alu_calc_ctrl_if.master                   alu_bus,
    output logic [31:0]                       accumulator,
    output logic                              acc_zero,
    output logic [$clog2(HIST_DEPTH+1)-1:0]   hist_count,
    output logic                              busy,
    output logic                              done
);

    localparam int CNT_W = $clog2(HIST_DEPTH + 1);
    localparam int PTR_W = $clog2(HIST_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HIST_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(HIST_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic go_pulse_s;
    logic undo_pulse_s;
    logic clear_pulse_s;

    calc_state_e state_r;
    calc_state_e state_nxt_s;

    logic clear_s;
    logic load_s;
    logic exec_s;
    logic pop_s;

    logic [31:0]      acc_r;
    logic             acc_zero_r;
    logic [3:0]       op_r;
    logic [31:0]      op2_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] top_r;
    logic [PTR_W-1:0] top_inc_s;
    logic [PTR_W-1:0] top_dec_s;
    logic             done_r;
    logic [31:0]      hist_mem_r [HIST_DEPTH];

    btn_oneshot u_go_os    (.clk(clk), .rst(rst), .in(go),    .pulse(go_pulse_s));
    btn_oneshot u_undo_os  (.clk(clk), .rst(rst), .in(undo),   .pulse(undo_pulse_s));
    btn_oneshot u_clear_os (.clk(clk), .rst(rst), .in(clear),  .pulse(clear_pulse_s));

    // top_r points at the next free slot; both directions wrap modulo HIST_DEPTH
    assign top_inc_s = (top_r == PTR_MAX) ? {PTR_W{1'b0}} : (top_r + PTR_ONE);
    assign top_dec_s = (top_r == {PTR_W{1'b0}}) ? PTR_MAX : (top_r - PTR_ONE);

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and action strobes; clear beats go beats undo, EXEC ignores pulses
    always_comb begin
        state_nxt_s = state_r;
        clear_s     = 1'b0;
        load_s      = 1'b0;
        exec_s      = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear_pulse_s) begin
                    clear_s = 1'b1;
                end else if (go_pulse_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = EXEC;
                end else if (undo_pulse_s && (count_r != {CNT_W{1'b0}})) begin
                    pop_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                exec_s      = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Accumulator, ALU operand latches, history bookkeeping and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r      <= 32'd0;
            acc_zero_r <= 1'b1;
            op_r       <= 4'd0;
            op2_r      <= 32'd0;
            count_r    <= {CNT_W{1'b0}};
            top_r      <= {PTR_W{1'b0}};
            done_r     <= 1'b0;
        end else begin
            done_r <= clear_s | exec_s | pop_s;
            if (clear_s) begin
                acc_r      <= 32'd0;
                acc_zero_r <= 1'b1;
                count_r    <= {CNT_W{1'b0}};
                top_r      <= {PTR_W{1'b0}};
            end else if (load_s) begin
                op_r  <= map_alu_op(op_sel);
                op2_r <= 32'($signed(operand));
            end else if (exec_s) begin
                acc_r      <= alu_bus.alu_result;
                acc_zero_r <= alu_bus.alu_zero;
                top_r      <= top_inc_s;
                // A push into a full history overwrites the oldest slot
                if (count_r != CNT_MAX) begin
                    count_r <= count_r + CNT_ONE;
                end
            end else if (pop_s) begin
                acc_r      <= hist_mem_r[top_dec_s];
                acc_zero_r <= (hist_mem_r[top_dec_s] == 32'd0);
                top_r      <= top_dec_s;
                count_r    <= count_r - CNT_ONE;
            end
        end
    end

    // History storage; contents are only meaningful below count_r
    always_ff @(posedge clk) begin
        if (exec_s && !rst) begin
            hist_mem_r[top_r] <= acc_r;
        end
    end

    assign alu_bus.alu_op  = op_r;
    assign alu_bus.alu_op1 = acc_r;
    assign alu_bus.alu_op2 = op2_r;

    assign accumulator = acc_r;
    assign acc_zero    = acc_zero_r;
    assign hist_count  = count_r;
    assign busy        = (state_r == EXEC);
    assign done        = done_r;

endmodule

// File: tb/tb_alu_calc_ctrl.sv
// Scoreboard bench for alu_calc_ctrl with a behavioural ALU on the bus and an
// op_sel-level reference model holding the accumulator and an undo list.
module tb_alu_calc_ctrl;
    import calc_pkg::*;

    localparam int OPERAND_W  = 16;
    localparam int HIST_DEPTH = 4;
    localparam int CNT_W      = $clog2(HIST_DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 go = 1'b0;
    logic                 undo = 1'b0;
    logic                 clear = 1'b0;
    logic [2:0]           op_sel = 3'd0;
    logic [OPERAND_W-1:0] operand = 16'd0;
    logic [31:0]          accumulator;
    logic                 acc_zero;
    logic [CNT_W-1:0]     hist_count;
    logic                 busy;
    logic                 done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;

    logic [31:0] exp_acc[$];
    int          exp_cnt[$];
    logic [31:0] m_acc = 32'd0;
    logic [31:0] m_hist[$];

    alu_calc_ctrl_if alu_bus();

    alu_calc_ctrl #(.OPERAND_W(OPERAND_W), .HIST_DEPTH(HIST_DEPTH)) dut (
        .clk(clk), .rst(rst), .go(go), .undo(undo), .clear(clear),
        .op_sel(op_sel), .operand(operand), .alu_bus(alu_bus),
        .accumulator(accumulator), .acc_zero(acc_zero), .hist_count(hist_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (busy) busy_cnt = busy_cnt + 1;

    // Behavioural ALU keyed by its own opcode table
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALUOP_ADD: return a + b;
            ALUOP_SUB: return a - b;
            ALUOP_AND: return a & b;
            ALUOP_OR:  return a | b;
            ALUOP_XOR: return a ^ b;
            ALUOP_LT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALUOP_SLL: return a << b[4:0];
            ALUOP_SRA: return $signed(a) >>> b[4:0];
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    logic [31:0] alu_res_s;
    always_comb alu_res_s = alu_f(alu_bus.alu_op, alu_bus.alu_op1, alu_bus.alu_op2);
    assign alu_bus.alu_result = alu_res_s;
    assign alu_bus.alu_zero   = (alu_res_s == 32'd0);

    // Reference calculation straight from the switch meaning
    function automatic logic [31:0] calc(input logic [2:0] sel, input logic [31:0] a, input logic [15:0] v);
        int signed sa;
        int signed sb;
        sa = a;
        sb = int'($signed(v));
        case (sel)
            3'd0: return a + sb;
            3'd1: return a - sb;
            3'd2: return a & sb;
            3'd3: return a | sb;
            3'd4: return a ^ sb;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a << v[4:0];
            default: return sa >>> v[4:0];
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp();
        exp_acc.push_back(m_acc);
        exp_cnt.push_back(m_hist.size());
    endtask

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin : monitor
        logic [31:0] ea;
        int ec;
        if (!rst && done) begin
            if (exp_acc.size() == 0) begin
                chk("unexpected_done_acc", accumulator, 32'hFFFF_FFFF ^ accumulator);
            end else begin
                ea = exp_acc.pop_front();
                ec = exp_cnt.pop_front();
                chk("acc", accumulator, ea);
                chk("acc_zero", {31'd0, acc_zero}, {31'd0, (ea == 32'd0)});
                chk("hist_count", {{(32-CNT_W){1'b0}}, hist_count}, 32'(ec));
            end
        end
    end

    task automatic do_go(input logic [2:0] s, input logic [15:0] v, input int hold);
        int gcyc;
        int lat;
        bit seen;
        m_hist.push_back(m_acc);
        if (m_hist.size() > HIST_DEPTH) void'(m_hist.pop_front());
        m_acc = calc(s, m_acc, v);
        push_exp();
        seen = 1'b0;
        lat = 0;
        @(negedge clk);
        op_sel = s;
        operand = v;
        go = 1'b1;
        gcyc = cyc;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == hold) go = 1'b0;
            if (done && !seen) begin
                seen = 1'b1;
                lat = cyc - gcyc;
            end
        end
        go = 1'b0;
        chk("go_latency", 32'(lat), 32'd5);
    endtask

    task automatic press(input bit u, input bit c);
        @(negedge clk);
        undo = u;
        clear = c;
        repeat (2) @(negedge clk);
        undo = 1'b0;
        clear = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_undo();
        if (m_hist.size() > 0) begin
            m_acc = m_hist.pop_back();
            push_exp();
        end
        press(1'b1, 1'b0);
    endtask

    task automatic do_clear();
        m_acc = 32'd0;
        m_hist.delete();
        push_exp();
        press(1'b0, 1'b1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_acc"}, accumulator, 32'd0);
        chk({tag, "_acc_zero"}, {31'd0, acc_zero}, 32'd1);
        chk({tag, "_hist"}, {{(32-CNT_W){1'b0}}, hist_count}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_alu_op"}, {28'd0, alu_bus.alu_op}, 32'd0);
        chk({tag, "_alu_op2"}, alu_bus.alu_op2, 32'd0);
    endtask

    initial begin
        int b0;
        int sel;
        bit seen_busy;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_state("reset");

        // ADD, SUB of -5, SUB to zero
        do_go(3'b000, 16'h0005, 2);
        do_go(3'b001, 16'hFFFB, 2);
        do_go(3'b001, 16'd10, 2);
        chk("sub_zero_flag", {31'd0, acc_zero}, 32'd1);

        // Shifts and signed compare
        do_clear();
        do_go(3'b000, 16'd1, 2);
        do_go(3'b110, 16'd31, 2);
        chk("sll_result", accumulator, 32'h8000_0000);
        do_go(3'b111, 16'd4, 2);
        chk("sra_result", accumulator, 32'hF800_0000);
        do_go(3'b101, 16'd0, 2);
        chk("lt_result", accumulator, 32'd1);

        // History overflow and underflow
        do_clear();
        for (int i = 0; i < 5; i++) do_go(3'b000, 16'd1, 2);
        for (int i = 0; i < 5; i++) do_undo();
        chk("undo_floor_acc", accumulator, 32'd1);
        chk("undo_floor_hist", {{(32-CNT_W){1'b0}}, hist_count}, 32'd0);

        // go and clear rising together
        do_clear();
        do_go(3'b000, 16'd7, 2);
        b0 = busy_cnt;
        m_acc = 32'd0;
        m_hist.delete();
        push_exp();
        @(negedge clk);
        op_sel = 3'b000;
        operand = 16'd9;
        go = 1'b1;
        clear = 1'b1;
        repeat (2) @(negedge clk);
        go = 1'b0;
        clear = 1'b0;
        repeat (10) @(negedge clk);
        chk("go_clear_acc", accumulator, 32'd0);
        chk("go_clear_no_exec", 32'(busy_cnt - b0), 32'd0);

        // Long press yields one update
        b0 = busy_cnt;
        do_go(3'b000, 16'd3, 20);
        repeat (5) @(negedge clk);
        chk("held_go_one_exec", 32'(busy_cnt - b0), 32'd1);

        // Reset landing in EXEC
        @(negedge clk);
        op_sel = 3'b000;
        operand = 16'd100;
        go = 1'b1;
        seen_busy = 1'b0;
        for (int i = 1; i <= 20 && !seen_busy; i++) begin
            @(negedge clk);
            if (i == 2) go = 1'b0;
            if (busy) seen_busy = 1'b1;
        end
        go = 1'b0;
        chk("exec_reached", {31'd0, seen_busy}, 32'd1);
        rst = 1'b1;
        m_acc = 32'd0;
        m_hist.delete();
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("exec_reset");
        repeat (6) @(negedge clk);

        // Randomized mix of operations
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                do_go(3'($urandom_range(0, 7)), 16'($urandom), 2);
            end else if (sel <= 8) begin
                do_undo();
            end else begin
                do_clear();
            end
        end

        repeat (5) @(negedge clk);
        chk("pending_expectations", 32'(exp_acc.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_calc_ctrl.md
Name: alu_calc_ctrl

Overview:
- Sequential controller that sits directly around the combinational `alu`.
- Drives the ALU's op1, op2 and alu_op, and consumes its result and zero flag.
- Keeps a 32-bit accumulator updated on debounced-clean button presses, plus a small undo history.
- Top-level calculator datapath for the board: switches and buttons in, accumulator to the LEDs/seven-segment.

Parameters:
- OPERAND_W, 16: width of the switch operand; sign-extended to 32 bits.
- HIST_DEPTH, 4: number of undo history entries; must be ≥2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- go  input  1  asynchronous button: execute op_sel on accumulator and operand
- undo  input  1  asynchronous button: restore previous accumulator
- clear  input  1  asynchronous button: zero accumulator, empty history
- op_sel  input  3  operation select (switches)
- operand  input  OPERAND_W  operand value (switches)
- alu_op  output  4  to ALU alu_op
- alu_op1  output  32  to ALU op1 (always the accumulator)
- alu_op2  output  32  to ALU op2 (registered, sign-extended operand)
- alu_result  input  32  from ALU result
- alu_zero  input  1  from ALU zero
- accumulator  output  32  current accumulator
- acc_zero  output  1  registered zero flag of accumulator
- hist_count  output  $clog2(HIST_DEPTH+1)  valid undo entries
- busy  output  1  high while state is EXEC
- done  output  1  one-cycle pulse after accumulator update

Behaviour:
- Reset (synchronous, active-high, any state, including mid-EXEC):
  - All of the following are 0 on the next edge: accumulator, acc_zero, alu_op2, alu_op, hist_count, busy, done, and the synchronizer and edge flops.
  - Exception: acc_zero resets to 1, since the accumulator is 0.
  - State returns to IDLE.
- Input conditioning:
  - go, undo and clear each pass through a 2-flop synchronizer and then a rising-edge detector: pulse = sync & ~sync_d.
  - Input-to-pulse latency is 3 cycles.
  - A held button yields exactly one pulse.
- op_sel to alu_op mapping:
  - 000 → ADD 0010
  - 001 → SUB 0110
  - 010 → AND 0000
  - 011 → OR 0001
  - 100 → XOR 1101
  - 101 → LT 0111
  - 110 → SLL 1001
  - 111 → SRA 1010
  - Undefined ALU codes are never emitted.
- FSM, two states, IDLE and EXEC:
  - IDLE + clear_pulse:
    - accumulator ← 0, acc_zero ← 1, hist_count ← 0.
    - done pulses the next cycle.
    - Stay IDLE.
  - IDLE + go_pulse (no clear):
    - Register alu_op ← map(op_sel) and alu_op2 ← sext(operand).
    - Go to EXEC.
  - EXEC (exactly 1 cycle; the ALU is combinational):
    - Push the old accumulator onto history.
    - accumulator ← alu_result, acc_zero ← alu_zero.
    - Return to IDLE; done = 1 in the following cycle.
  - IDLE + undo_pulse (no clear or go), hist_count > 0:
    - Pop: accumulator ← top entry, acc_zero ← (entry == 0), hist_count −1.
    - done pulses.
  - IDLE + undo_pulse, hist_count == 0: no change and no done.
  - Priority within one cycle: clear > go > undo. Lower-priority pulses in the same cycle are dropped.
  - Pulses arriving while in EXEC are dropped, not queued.
- History buffer:
  - Circular LIFO of HIST_DEPTH × 32 with a top pointer that wraps modulo HIST_DEPTH.
  - Push when full: the oldest entry is overwritten and hist_count stays at HIST_DEPTH.
  - Undo can never restore a value older than HIST_DEPTH operations.
- Go-to-update latency: go_pulse in cycle N → EXEC in N+1 → accumulator and done valid in N+2.
- alu_op1 is combinationally the accumulator; alu_op and alu_op2 hold their last values while in IDLE.

Decomposition:
- Package calc_pkg holds:
  - the ALUOP_* 4-bit constants, shared with the ALU and its bench;
  - the op_sel encoding constants;
  - the state enum typedef {IDLE, EXEC}.
- One sub-module, btn_oneshot: 2-flop synchronizer plus rising-edge detector, with ports clk, rst, in, pulse. Instantiated 3 times.

Test Plan:
- Reset, then go with op_sel=000 and operand=16'h0005 → accumulator=5, done 5 cycles after go rises, acc_zero=0, hist_count=1.
- Accumulator=5, then go with op_sel=001 and operand=16'hFFFB (−5) → accumulator=10. Then SUB with 10 → accumulator=0, acc_zero=1.
- Accumulator=32'h80000000 via SLL of 1 by 31, then SRA by operand 4 → 32'hF8000000. Also check LT (op_sel=101) with operand 0 → 1.
- Five consecutive ADDs of 1 from 0 (HIST_DEPTH=4):
  - Undo four times → 4, 3, 2, 1, with hist_count reaching 0.
  - A fifth undo → accumulator stays 1, no done.
- go and clear rising in the same cycle with accumulator=7 → accumulator=0, hist_count=0, no EXEC.
- go held high for 20 cycles → exactly one update.
- rst asserted during EXEC → all outputs at reset values next cycle; no done.
